fetch_pc_ctrl: RTL and testbench
================================

# fetch_pc_ctrl

Fetch-stage PC sequencer and instruction-cache front end. It holds the program counter and issues fetch requests to the instruction cache. It delivers instructions into the fetch/decode pipeline register. It also consumes the resolved `branch` decision from the branch condition lookup in the decode stage, redirecting the PC and flushing the wrong-path instruction. It handles cache miss latency, pipeline stalls, and HLT.

## Interface
- `PC_W`, 16, PC / address width
- `OFF_W`, 9, branch immediate width (word offset, signed)
- `RESET_PC`, 16'h0000, PC after reset
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `branch`  in  1  taken-branch decision from branch condition lookup (already gated by branch control)
- `br_pc`  in  PC_W  PC+2 of the branch instruction
- `br_offset`  in  OFF_W  signed branch immediate
- `br_reg`  in  1  1 = register-indirect target (BR), 0 = PC-relative (B)
- `br_reg_val`  in  PC_W  register target value
- `stall`  in  1  hazard-unit stall; hold fetch/decode register
- `halt`  in  1  decode stage holds HLT
- `icache_req`  out  1  fetch request
- `icache_addr`  out  PC_W  fetch address
- `icache_rdy`  in  1  instruction data valid this cycle (same cycle as req on hit)
- `icache_data`  in  16  instruction word
- `instr`  out  16  fetch/decode register instruction
- `instr_valid`  out  1  `instr` is a live instruction
- `pc_plus2`  out  PC_W  PC+2 of `instr`
- `flush`  out  1  combinational, equals `branch`; kills the decode-stage instruction

## Operation
- Target: `br_reg` ? `br_reg_val` : `br_pc` + (sext(`br_offset`) << 1), computed modulo 2^PC_W (wraps, no overflow flag).
- Priority every cycle: `branch` > `halt` > `stall` > normal fetch.
- States: FETCH, WAIT (miss outstanding), HOLD (returned word buffered during stall), HALT.
- FETCH:
  - `icache_req` = !`stall` && !`branch`.
  - `icache_addr` = pc.
  - Req && rdy: `instr`<=data, `instr_valid`<=1, `pc_plus2`<=pc+2, pc<=pc+2; stay FETCH.
  - Req && !rdy: go WAIT; pc and address held.
- WAIT:
  - `icache_req`=1 and `icache_addr`=pc held stable until rdy. An outstanding request is never aborted.
  - `branch` in WAIT: latch target into redirect register, set pending. A later branch overwrites the target.
  - On rdy with pending set: discard data, pc<=redirect target, clear pending, go FETCH, `instr_valid`<=0.
  - On rdy, no pending, `stall`=1: store data in buffer, go HOLD.
  - On rdy, no pending, `stall`=0: deliver as in FETCH, go FETCH.
  - `branch` on the same cycle as rdy counts as pending: data is discarded.
- HOLD:
  - `icache_req`=0.
  - When `stall` drops: deliver buffer, pc<=pc+2, go FETCH.
  - `branch`: drop buffer, pc<=target, go FETCH.
- `branch` (FETCH/HOLD): pc<=target, `instr_valid`<=0 next edge.
- `halt`:
  - `halt` without `branch`: go HALT at the next edge; an outstanding WAIT completes first and its data is discarded.
  - In HALT: `icache_req`=0, `instr_valid`<=0.
  - Exit from HALT only by reset.
- `stall` without `branch` (FETCH): `instr`, `instr_valid`, `pc_plus2`, pc all hold.

## Timing
- Reset (async, while `rst_n`=0):
  - pc=RESET_PC, state FETCH, pending=0.
  - `instr`=16'h0000, `instr_valid`=0, `pc_plus2`=0.
  - `icache_req` forced 0 while `rst_n` low.
- First request on the first edge after reset release.
- Hit latency: request cycle N → `instr_valid`=1 from edge ending N.
- Throughput: 1 instruction/cycle on hits.
- Taken-branch penalty: branch seen in cycle N. No request in N. Target requested in N+1. Target valid after edge ending N+1 (hit).
- Miss of k cycles: `instr_valid` low for k cycles, then 1.
- Reset mid-WAIT: request dropped immediately; the cache must tolerate an abandoned request.

## Test plan
- Reset, all hits, `icache_data`=addr: `icache_addr` = 0,2,4,6 on consecutive cycles. `instr`/`pc_plus2` = 0/2, 2/4, 4/6 one cycle later.
- PC-relative branch: `branch`=1, `br_pc`=16'h0010, `br_offset`=9'h1FE (−2). `flush`=1 that cycle, `icache_req`=0. Next cycle `icache_addr`=16'h000C. `instr_valid`=0 for exactly one cycle.
- Wrap and BR: `br_reg`=1, `br_reg_val`=16'hFFFE, then all hits. Fetches 16'hFFFE then 16'h0000.
- Miss with redirect: pc=16'h0020, rdy held low 4 cycles, `branch` to 16'h0100 in cycle 2. `icache_addr` stays 16'h0020 until rdy. Returned word discarded, never valid. Next request = 16'h0100.
- Miss completes under stall: rdy arrives while `stall`=1. No new req, `instr` unchanged. Stall drops → buffered word delivered, next req = pc+2.
- HLT: `halt`=1 at pc=16'h0008. `icache_req`=0 forever, `instr_valid`=0. `rst_n` pulse restarts fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer and instruction-cache front end.
// Holds the PC, issues cache requests, fills the fetch/decode register and applies branch redirects.
module fetch_pc_ctrl #(
    parameter int unsigned         PC_W     = 16,
    parameter int unsigned         OFF_W    = 9,
    parameter logic [PC_W-1:0]     RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              branch,
    input  logic [PC_W-1:0]   br_pc,
    input  logic [OFF_W-1:0]  br_offset,
    input  logic              br_reg,
    input  logic [PC_W-1:0]   br_reg_val,
    input  logic              stall,
    input  logic              halt,
    output logic              icache_req,
    output logic [PC_W-1:0]   icache_addr,
    input  logic              icache_rdy,
    input  logic [15:0]       icache_data,
    output logic [15:0]       instr,
    output logic              instr_valid,
    output logic [PC_W-1:0]   pc_plus2,
    output logic              flush
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic [PC_W-1:0]   pc2_q, pc2_d;
    logic [15:0]       buf_q, buf_d;
    logic [PC_W-1:0]   redir_q, redir_d;
    logic              pend_q, pend_d;
    logic              hpend_q, hpend_d;

    logic [PC_W-1:0]   off_ext;
    logic [PC_W-1:0]   target;
    logic [PC_W-1:0]   pc_inc;
    logic              req_raw;

    // Word offset sign-extended then scaled to bytes; the sum wraps modulo 2^PC_W.
    assign off_ext = {{(PC_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};
    assign target  = br_reg ? br_reg_val : br_pc + {off_ext[PC_W-2:0], 1'b0};
    assign pc_inc  = pc_q + PC_W'(2);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (branch)           state_d = S_FETCH;
                else if (halt)        state_d = S_HALT;
                else if (stall)       state_d = S_FETCH;
                else if (!icache_rdy) state_d = S_WAIT;
                else                  state_d = S_FETCH;
            end
            S_WAIT: begin
                if (icache_rdy) begin
                    if (branch || pend_q)      state_d = S_FETCH;
                    else if (halt || hpend_q)  state_d = S_HALT;
                    else if (stall)            state_d = S_HOLD;
                    else                       state_d = S_FETCH;
                end
            end
            S_HOLD: begin
                if (branch)      state_d = S_FETCH;
                else if (halt)   state_d = S_HALT;
                else if (!stall) state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        req_raw = 1'b0;
        unique case (state_q)
            S_FETCH: req_raw = !stall && !branch && !halt;
            S_WAIT:  req_raw = 1'b1;
            S_HOLD:  req_raw = 1'b0;
            S_HALT:  req_raw = 1'b0;
            default: req_raw = 1'b0;
        endcase
    end

    // Reset drops an outstanding request at once, without waiting for a clock.
    assign icache_req  = req_raw & rst_n;
    assign icache_addr = pc_q;
    assign flush       = branch;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc_plus2    = pc2_q;

    // ---------------- datapath next values ----------------
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        pc2_d   = pc2_q;
        buf_d   = buf_q;
        redir_d = redir_q;
        pend_d  = pend_q;
        hpend_d = hpend_q;

        unique case (state_q)
            S_FETCH: begin
                if (branch) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                end else if (halt) begin
                    valid_d = 1'b0;
                end else if (!stall) begin
                    if (icache_rdy) begin
                        instr_d = icache_data;
                        valid_d = 1'b1;
                        pc2_d   = pc_inc;
                        pc_d    = pc_inc;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end

            S_WAIT: begin
                // A redirect or halt seen mid-miss is remembered until the cache answers.
                if (branch) begin
                    redir_d = target;
                    pend_d  = 1'b1;
                    hpend_d = 1'b0;
                end else if (halt) begin
                    hpend_d = 1'b1;
                end

                if (icache_rdy) begin
                    if (branch || pend_q) begin
                        pc_d    = branch ? target : redir_q;
                        pend_d  = 1'b0;
                        hpend_d = 1'b0;
                        valid_d = 1'b0;
                    end else if (halt || hpend_q) begin
                        hpend_d = 1'b0;
                        valid_d = 1'b0;
                    end else if (stall) begin
                        buf_d   = icache_data;
                    end else begin
                        instr_d = icache_data;
                        valid_d = 1'b1;
                        pc2_d   = pc_inc;
                        pc_d    = pc_inc;
                    end
                end else if (branch || halt || !stall) begin
                    valid_d = 1'b0;
                end
            end

            S_HOLD: begin
                if (branch) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                end else if (halt) begin
                    valid_d = 1'b0;
                end else if (!stall) begin
                    instr_d = buf_q;
                    valid_d = 1'b1;
                    pc2_d   = pc_inc;
                    pc_d    = pc_inc;
                end
            end

            S_HALT: begin
                valid_d = 1'b0;
            end

            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            pc2_q   <= '0;
            buf_q   <= '0;
            redir_q <= '0;
            pend_q  <= 1'b0;
            hpend_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            pc2_q   <= pc2_d;
            buf_q   <= buf_d;
            redir_q <= redir_d;
            pend_q  <= pend_d;
            hpend_q <= hpend_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: cache model returns the address as data,
// a scoreboard queue holds expected deliveries until the fetch/decode register shows them.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        branch = 1'b0;
    logic [15:0] br_pc = '0;
    logic [8:0]  br_offset = '0;
    logic        br_reg = 1'b0;
    logic [15:0] br_reg_val = '0;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        icache_req;
    logic [15:0] icache_addr;
    logic        icache_rdy = 1'b1;
    logic [15:0] icache_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc_plus2;
    logic        flush;

    typedef struct packed {
        logic [15:0] ins;
        logic [15:0] p2;
    } exp_t;

    exp_t        sbq[$];
    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    assign icache_data = icache_addr;

    fetch_pc_ctrl #(
        .PC_W     (16),
        .OFF_W    (9),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .branch      (branch),
        .br_pc       (br_pc),
        .br_offset   (br_offset),
        .br_reg      (br_reg),
        .br_reg_val  (br_reg_val),
        .stall       (stall),
        .halt        (halt),
        .icache_req  (icache_req),
        .icache_addr (icache_addr),
        .icache_rdy  (icache_rdy),
        .icache_data (icache_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc_plus2    (pc_plus2),
        .flush       (flush)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // exp_req = x skips the request check for that cycle.
    task automatic step(input string tag, input logic exp_req, input logic [15:0] exp_addr,
                        input bit push, input logic exp_v, input bit pop);
        exp_t e;
        #2;
        chk({tag, ".flush"}, {15'b0, flush}, {15'b0, branch});
        if (exp_req !== 1'bx) begin
            chk({tag, ".req"}, {15'b0, icache_req}, {15'b0, exp_req});
            if (exp_req === 1'b1) chk({tag, ".addr"}, icache_addr, exp_addr);
        end
        if (push) begin
            e.ins = exp_addr;
            e.p2  = exp_addr + 16'd2;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, {15'b0, instr_valid}, {15'b0, exp_v});
        if (pop) begin
            chk({tag, ".sb_nonempty"}, {15'b0, sbq.size() != 0}, 16'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk({tag, ".instr"}, instr, e.ins);
                chk({tag, ".pc_plus2"}, pc_plus2, e.p2);
            end
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".req"},      {15'b0, icache_req},  16'd0);
        chk({tag, ".instr"},    instr,                16'h0000);
        chk({tag, ".valid"},    {15'b0, instr_valid}, 16'd0);
        chk({tag, ".pc_plus2"}, pc_plus2,             16'h0000);
    endtask

    initial begin
        // reset
        #1;
        check_reset("rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset("rst_hold");
        rst_n = 1'b1;

        // sequential hits
        step("hit0", 1'b1, 16'h0000, 1, 1'b1, 1);
        step("hit2", 1'b1, 16'h0002, 1, 1'b1, 1);
        step("hit4", 1'b1, 16'h0004, 1, 1'b1, 1);
        step("hit6", 1'b1, 16'h0006, 1, 1'b1, 1);

        // PC-relative branch, offset -2 words
        branch = 1'b1; br_pc = 16'h0010; br_offset = 9'h1FE;
        step("br_rel", 1'b0, 16'h0000, 0, 1'b0, 0);
        branch = 1'b0;
        step("br_tgt", 1'b1, 16'h000C, 1, 1'b1, 1);
        step("br_seq", 1'b1, 16'h000E, 1, 1'b1, 1);

        // register-indirect branch and PC wrap
        branch = 1'b1; br_reg = 1'b1; br_reg_val = 16'hFFFE;
        step("br_reg", 1'b0, 16'h0000, 0, 1'b0, 0);
        branch = 1'b0; br_reg = 1'b0;
        step("wrap_fffe", 1'b1, 16'hFFFE, 1, 1'b1, 1);
        step("wrap_0000", 1'b1, 16'h0000, 1, 1'b1, 1);

        // miss with a redirect arriving mid-miss
        branch = 1'b1; br_reg = 1'b1; br_reg_val = 16'h0020;
        step("to20", 1'b0, 16'h0000, 0, 1'b0, 0);
        branch = 1'b0; br_reg = 1'b0; icache_rdy = 1'b0;
        step("miss1", 1'b1, 16'h0020, 0, 1'b0, 0);
        branch = 1'b1; br_reg = 1'b1; br_reg_val = 16'h0100;
        step("miss2_br", 1'b1, 16'h0020, 0, 1'b0, 0);
        branch = 1'b0; br_reg = 1'b0;
        step("miss3", 1'b1, 16'h0020, 0, 1'b0, 0);
        step("miss4", 1'b1, 16'h0020, 0, 1'b0, 0);
        icache_rdy = 1'b1;
        step("miss_ret", 1'b1, 16'h0020, 0, 1'b0, 0);
        step("redir", 1'b1, 16'h0100, 1, 1'b1, 1);

        // miss completing under stall
        icache_rdy = 1'b0;
        step("sm_miss", 1'b1, 16'h0102, 0, 1'b0, 0);
        stall = 1'b1;
        step("sm_wait", 1'b1, 16'h0102, 0, 1'b0, 0);
        icache_rdy = 1'b1;
        step("sm_rdy", 1'b1, 16'h0102, 1, 1'b0, 0);
        chk("sm_instr_held", instr, 16'h0100);
        step("sm_hold", 1'b0, 16'h0000, 0, 1'b0, 0);
        chk("sm_hold_instr", instr, 16'h0100);
        stall = 1'b0;
        step("sm_release", 1'b0, 16'h0000, 0, 1'b1, 1);
        step("sm_next", 1'b1, 16'h0104, 1, 1'b1, 1);

        // stall in FETCH holds the decode register
        stall = 1'b1;
        step("f_stall", 1'b0, 16'h0000, 0, 1'b1, 0);
        chk("f_stall_instr", instr, 16'h0104);
        chk("f_stall_pc2", pc_plus2, 16'h0106);
        stall = 1'b0;
        step("f_resume", 1'b1, 16'h0106, 1, 1'b1, 1);

        // halt at pc 0x0008, only reset restarts fetch
        branch = 1'b1; br_reg = 1'b1; br_reg_val = 16'h0008;
        step("to8", 1'b0, 16'h0000, 0, 1'b0, 0);
        branch = 1'b0; br_reg = 1'b0; halt = 1'b1;
        step("halt", 1'bx, 16'h0000, 0, 1'b0, 0);
        halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("halted", 1'b0, 16'h0000, 0, 1'b0, 0);
        end
        rst_n = 1'b0;
        #1;
        check_reset("rst2");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("restart0", 1'b1, 16'h0000, 1, 1'b1, 1);
        step("restart2", 1'b1, 16'h0002, 1, 1'b1, 1);

        chk("sb_drain", 16'(sbq.size()), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed run still active expected finish");
        $fatal(1, "timeout");
    end

endmodule
